// File: rtl/ram_loader.sv
// ram_loader: streams DEPTH nibbles into a small RAM over a valid/ready
// handshake, reads the array back and compares write/read checksums.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | waiting for start; RAM deselected
// S_LOAD   | in_ready high, waiting for a nibble
// S_WRITE  | one-cycle RAM write of the held nibble at ptr
// S_VERIFY | one RAM read per cycle, accumulating the read checksum
// S_CHECK  | compare checksums, latch pass
// S_DONE   | one-cycle done pulse
module ram_loader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [DATA_W-1:0] i_in_data,
    output logic              o_in_ready,
    output logic              o_ram_cs,
    output logic              o_ram_write_en,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass
);

    localparam int              DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WRITE,
        S_VERIFY,
        S_CHECK,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_ptr;
    logic [DATA_W-1:0]   r_hold;
    logic [DATA_W-1:0]   r_sum_w;
    logic [DATA_W-1:0]   r_sum_r;
    logic                r_pass;
    logic                w_accept;
    logic                w_last;

    // A nibble is taken only while LOAD advertises ready.
    assign w_accept = (r_state == S_LOAD) && i_in_valid;
    assign w_last   = (r_ptr == LAST_ADDR);
    assign o_pass   = r_pass;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and outputs; RAM-side outputs decode from state and registers only.
    always_comb begin
        w_next         = r_state;
        o_in_ready     = 1'b0;
        o_ram_cs       = 1'b0;
        o_ram_write_en = 1'b1;
        o_ram_addr     = '0;
        o_ram_wdata    = '0;
        o_busy         = 1'b1;
        o_done         = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: begin
                o_in_ready = 1'b1;
                if (w_accept) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_ram_cs       = 1'b1;
                o_ram_write_en = 1'b0;
                o_ram_addr     = r_ptr;
                o_ram_wdata    = r_hold;
                w_next         = w_last ? S_VERIFY : S_LOAD;
            end
            S_VERIFY: begin
                o_ram_cs   = 1'b1;
                o_ram_addr = r_ptr;
                if (w_last) begin
                    w_next = S_CHECK;
                end
            end
            S_CHECK: begin
                w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Datapath: address pointer, held nibble, running checksums and verdict.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr   <= '0;
            r_hold  <= '0;
            r_sum_w <= '0;
            r_sum_r <= '0;
            r_pass  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ptr   <= '0;
                        r_sum_w <= '0;
                        r_sum_r <= '0;
                        r_pass  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_hold  <= i_in_data;
                        r_sum_w <= r_sum_w + i_in_data;
                    end
                end
                S_WRITE: begin
                    // The pointer is rewound here so VERIFY reads from address 0.
                    r_ptr <= w_last ? '0 : r_ptr + 1'b1;
                end
                S_VERIFY: begin
                    r_sum_r <= r_sum_r + i_ram_rdata;
                    if (!w_last) begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                S_CHECK: begin
                    r_pass <= (r_sum_r == r_sum_w);
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: directed sessions against a behavioural 16x4 RAM model.
module tb_ram_loader;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_in_valid = 1'b0;
    logic [3:0] i_in_data = 4'h0;
    logic       o_in_ready;
    logic       o_ram_cs;
    logic       o_ram_write_en;
    logic [3:0] o_ram_addr;
    logic [3:0] o_ram_wdata;
    logic [3:0] i_ram_rdata;
    logic       o_busy;
    logic       o_done;
    logic       o_pass;

    logic [3:0] mem [16];
    logic [3:0] exp_data [16];
    logic       corrupt = 1'b0;
    int         wr_cnt = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    ram_loader #(.DATA_W(4), .ADDR_W(4)) u_dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_in_valid     (i_in_valid),
        .i_in_data      (i_in_data),
        .o_in_ready     (o_in_ready),
        .o_ram_cs       (o_ram_cs),
        .o_ram_write_en (o_ram_write_en),
        .o_ram_addr     (o_ram_addr),
        .o_ram_wdata    (o_ram_wdata),
        .i_ram_rdata    (i_ram_rdata),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass)
    );

    always #5 i_clk = ~i_clk;

    // RAM model: synchronous write, combinational read, optional bit-0 fault at addr 5.
    always @(posedge i_clk) begin
        if (o_ram_cs && !o_ram_write_en) mem[o_ram_addr] <= o_ram_wdata;
    end
    assign i_ram_rdata = mem[o_ram_addr] ^
        {3'b000, corrupt && o_ram_cs && o_ram_write_en && (o_ram_addr == 4'd5)};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Bus monitor: write ordering/data and RAM-interface invariants every cycle.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            if (!o_busy) wr_cnt = 0;
            if (o_ram_cs && !o_ram_write_en) begin
                chk("wr_addr", o_ram_addr, wr_cnt);
                chk("wr_data", o_ram_wdata, exp_data[wr_cnt[3:0]]);
                wr_cnt++;
                chk("wr_over", wr_cnt <= 16, 1);
            end
            if (!o_ram_write_en) begin
                chk("we_cs", o_ram_cs, 1);
                chk("we_rdy", o_in_ready, 0);
            end
            if (!o_ram_cs) begin
                chk("idle_addr", o_ram_addr, 0);
                chk("idle_wdata", o_ram_wdata, 0);
            end
            if (o_in_ready) begin
                chk("rdy_cs", o_ram_cs, 0);
                chk("rdy_busy", o_busy, 1);
            end
        end
    end

    // One load session; rst_addr >= 0 aborts with reset during the write to that address.
    task automatic run_load(input int max_gap, input bit poke, input int rst_addr,
                            input int exp_cyc, input bit exp_pass);
        int idx;
        int gap;
        int cyc;
        bit acc;
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        chk("load_busy", o_busy, 1);
        chk("load_rdy", o_in_ready, 1);
        idx = 0;
        gap = 0;
        cyc = 1;
        while (!o_done && cyc < 400) begin
            if (rst_addr >= 0 && o_ram_cs && !o_ram_write_en && o_ram_addr == rst_addr[3:0]) begin
                i_rst = 1'b1;
                i_in_valid = 1'b0;
                @(posedge i_clk);
                #1;
                chk("rst_cs", o_ram_cs, 0);
                chk("rst_busy", o_busy, 0);
                chk("rst_pass", o_pass, 0);
                chk("rst_rdy", o_in_ready, 0);
                chk("rst_we", o_ram_write_en, 1);
                i_rst = 1'b0;
                return;
            end
            if (gap > 0) begin
                i_in_valid = 1'b0;
                gap--;
            end else begin
                i_in_valid = (idx < 16);
                i_in_data = exp_data[(idx < 16) ? idx : 0];
            end
            i_start = poke && (cyc == 3 || cyc == 40);
            acc = i_in_valid && o_in_ready;
            @(posedge i_clk);
            #1;
            cyc++;
            if (acc) begin
                idx++;
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            end
        end
        i_start = 1'b0;
        i_in_valid = 1'b0;
        chk("done_seen", o_done, 1);
        if (exp_cyc > 0) chk("done_cyc", cyc, exp_cyc);
        chk("pass", o_pass, exp_pass);
        chk("n_writes", wr_cnt, 16);
        chk("n_accept", idx, 16);
        @(posedge i_clk);
        #1;
        chk("done_width", o_done, 0);
        chk("back_idle", o_busy, 0);
        chk("pass_hold", o_pass, exp_pass);
    endtask

    initial begin
        logic [3:0] bp [16];
        bp = '{4'h3, 4'h1, 4'h4, 4'h1, 4'h5, 4'h9, 4'h2, 4'h6,
               4'h5, 4'h3, 4'h5, 4'h8, 4'h9, 4'h7, 4'h9, 4'h3};
        for (int i = 0; i < 16; i++) mem[i] = 4'h0;

        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_state_busy", o_busy, 0);
        chk("rst_state_rdy", o_in_ready, 0);
        chk("rst_state_cs", o_ram_cs, 0);
        chk("rst_state_we", o_ram_write_en, 1);
        chk("rst_state_addr", o_ram_addr, 0);
        chk("rst_state_wdata", o_ram_wdata, 0);
        chk("rst_state_done", o_done, 0);
        chk("rst_state_pass", o_pass, 0);
        i_rst = 1'b0;

        // Ramp 0..15: sum 120 -> 0x8 on both sides.
        for (int i = 0; i < 16; i++) exp_data[i] = 4'(i);
        run_load(0, 1'b0, -1, 50, 1'b1);

        // Read-side fault at address 5.
        corrupt = 1'b1;
        run_load(0, 1'b0, -1, 50, 1'b0);
        corrupt = 1'b0;

        // Backpressure with gaps of 0..3 cycles.
        for (int i = 0; i < 16; i++) exp_data[i] = bp[i];
        run_load(3, 1'b0, -1, -1, 1'b1);

        // Start pulses during LOAD and VERIFY are ignored.
        for (int i = 0; i < 16; i++) exp_data[i] = 4'(i);
        run_load(0, 1'b1, -1, 50, 1'b1);

        // Reset after the write to address 7, then a fresh session from address 0.
        run_load(0, 1'b0, 7, -1, 1'b0);
        run_load(0, 1'b0, -1, 50, 1'b1);

        // All 0xF: sum 240 -> 0x0.
        for (int i = 0; i < 16; i++) exp_data[i] = 4'hF;
        run_load(0, 1'b0, -1, 50, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ram_loader.md
# ram_loader

Initiator-side sequencer for the 16 x 4 program/data RAM of the 4-bit computer. It accepts a stream of nibbles over a valid/ready handshake and writes them to consecutive RAM addresses 0..DEPTH-1. It then reads the whole array back and compares a modulo-2^DATA_W checksum of the read data against the checksum of the written data. It drives the RAM's chip-select / active-low write-enable / address / data interface and sits between the front-panel or serial input logic and the RAM.

## Interface
- DATA_W, 4, RAM word width
- ADDR_W, 4, RAM address width; DEPTH = 2**ADDR_W (16)
- clk  input  1  rising-edge clock for the whole block
- rst  input  1  synchronous, active-high reset
- start  input  1  begin a load session; sampled only in IDLE
- in_valid  input  1  in_data holds a nibble to load
- in_data  input  DATA_W  nibble to write
- in_ready  output  1  block accepts in_data this cycle
- ram_cs  output  1  RAM chip select, active high
- ram_write_en  output  1  RAM write enable, active LOW (0 = write, 1 = read)
- ram_addr  output  ADDR_W  RAM address
- ram_wdata  output  DATA_W  data to RAM
- ram_rdata  input  DATA_W  data from RAM (combinational read of ram_addr)
- busy  output  1  session in progress (any state except IDLE)
- done  output  1  one-cycle pulse at end of session
- pass  output  1  verify result, valid from the done pulse, held until next accepted start

## Operation
- States: IDLE, LOAD, WRITE, VERIFY, CHECK, DONE.
- IDLE: in_ready=0, ram_cs=0, ram_write_en=1, busy=0. start=1 -> LOAD; ptr, sum_w, sum_r cleared; pass cleared.
- LOAD: in_ready=1, RAM idle (cs=0). An accepted nibble (in_valid & in_ready) is latched into hold, sum_w += in_data (mod 2^DATA_W), -> WRITE. No accept -> stay.
- WRITE: in_ready=0; ram_cs=1, ram_write_en=0, ram_addr=ptr, ram_wdata=hold. If ptr==DEPTH-1, then ptr<=0 and -> VERIFY; else ptr++ and -> LOAD.
- VERIFY: ram_cs=1, ram_write_en=1, ram_addr=ptr; at the closing edge sum_r += ram_rdata. If ptr==DEPTH-1, -> CHECK; else ptr++.
- CHECK: RAM idle; pass <= (sum_r == sum_w); -> DONE.
- DONE: done=1 for this single cycle; -> IDLE.
- RAM-side outputs depend only on state and internal registers; no combinational path from in_valid/in_data/start.
- ram_write_en is never 0 unless ram_cs=1 and state is WRITE. ram_addr and ram_wdata are 0 whenever ram_cs=0.
- start while busy is ignored. in_valid outside LOAD is ignored.
- ptr wraps only by the explicit reset to 0 at the WRITE->VERIFY transition; it never counts past DEPTH-1.

## Timing
- Reset (rst=1 at an edge): state=IDLE, ptr=0, sums=0, hold=0, in_ready=0, ram_cs=0, ram_write_en=1, ram_addr=0, ram_wdata=0, busy=0, done=0, pass=0.
- Reset mid-session aborts immediately. The RAM is deselected from the cycle after the reset edge, and partial RAM contents are left as-is.
- start sampled at edge N -> LOAD (in_ready=1, busy=1) in cycle N+1.
- Per nibble: accept cycle plus one WRITE cycle. Minimum load time is 2*DEPTH = 32 cycles with in_valid held high.
- VERIFY takes exactly DEPTH cycles. CHECK takes 1 cycle and DONE takes 1 cycle.
- Minimum total from start sample to done pulse: 1 + 32 + 16 + 1 = 50 cycles. The block is back in IDLE and can accept start on the cycle after done.
- pass updates at the edge entering DONE, so it is valid in the same cycle as done=1.

## Test plan
- Load 0..15 with in_valid held high. Required: writes at addr 0..15 in WRITE cycles, sum 120 mod 16 = 0x8 on both sides, done at cycle 50, pass=1.
- Same load, but the bench RAM model flips bit 0 of ram_rdata at addr 5 during read. Required: pass=0 with done, and no extra writes.
- Backpressure: in_valid randomly low for 0..3 cycles between nibbles. Required: in_ready=1 only in LOAD, exactly 16 writes in address order, ram_write_en=0 only in WRITE cycles.
- Pulse start during LOAD and again during VERIFY. Required: ignored, ptr and sums unaffected, single done pulse.
- Assert rst after the write to addr 7. Required: next cycle ram_cs=0, busy=0, pass=0. A fresh start then writes from addr 0.
- Load all nibbles 0xF. Required: sum 240 mod 16 = 0x0 on both sides, pass=1, done exactly one cycle wide.
